mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous data/instruction RAM between the instruction-fetch path and the load/store path of the RV32I core.
- Performs fair arbitration and at most one outstanding RAM transaction.
- Generates store byte enables and lane replication, and performs load byte/halfword extraction with sign or zero extension.
- Reports misaligned accesses and illegal modes.
- Sits between the main control unit / datapath and the RAM, so a second RAM port is not required.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the instruction/data RAM port arbiter: access modes,
// grant owner, arbiter state and the load/store mode legality check.
package mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_mode_t;

    // Stores share the funct3 codes of the signed loads.
    localparam mem_mode_t SB = LB;
    localparam mem_mode_t SH = LH;
    localparam mem_mode_t SW = LW;

    typedef enum logic {
        GR_IF = 1'b0,
        GR_D  = 1'b1
    } grant_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic is_legal_mode(input logic wen, input logic [2:0] mode);
        case (mode)
            3'b000, 3'b001, 3'b010: is_legal_mode = 1'b1;
            3'b100, 3'b101:         is_legal_mode = !wen;
            default:                is_legal_mode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling between the 32-bit core data bus and the RAM word:
// store enables/replication, misalignment detect and load extraction.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  req_mode,
    input  logic [1:0]  req_a,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_mode,
    input  logic [1:0]  ld_a,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        case (req_mode)
            SB: begin
                st_be    = 4'b0001 << req_a;
                st_wdata = {4{req_wdata[7:0]}};
            end
            SH: begin
                st_be    = req_a[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Covers LH/LHU/SH (x01) and LW/SW (010); illegal codes are flagged elsewhere.
    assign misaligned = ((req_mode[1:0] == 2'b01) && req_a[0]) ||
                        ((req_mode[1:0] == 2'b10) && (req_a != 2'b00));

    always_comb begin
        case (ld_a)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_a[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_mode)
            LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
            LBU:     ld_data = {24'd0, ld_byte};
            LH:      ld_data = {{16{ld_half[15]}}, ld_half};
            LHU:     ld_data = {16'd0, ld_half};
            LW:      ld_data = ld_rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store with
// round-robin arbitration and at most one transaction in flight.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output arb_state_t  dbg_state
);

    // Handshake: a requester holds *_req and its operands stable until the cycle
    // *_ready pulses; the request is taken in that cycle. The response is a single
    // *_rvalid pulse RAM_LAT cycles later and cannot be stalled.
    localparam logic [1:0] CNT_LAST = 2'(RAM_LAT - 1);

    arb_state_t  state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    grant_t      last_grant, last_grant_nxt;
    grant_t      cap_gr;
    logic [1:0]  cap_a;
    logic [2:0]  cap_mode;
    logic        cap_wen, cap_err;

    logic        busy_last, can_issue, grant_d, grant_if, issue, done;
    logic        d_misaligned, d_err_req, if_err_req;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    mem_lane_align u_align (
        .req_mode  (d_mode),
        .req_a     (d_addr[1:0]),
        .req_wdata (d_wdata),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .misaligned(d_misaligned),
        .ld_mode   (cap_mode),
        .ld_a      (cap_a),
        .ld_rdata  (ram_rdata),
        .ld_data   (ld_data)
    );

    // The final BUSY cycle both retires the old transaction and may issue a new one.
    assign busy_last  = (state == BUSY) && (cnt == CNT_LAST);
    assign can_issue  = !rst && ((state == IDLE) || busy_last);
    assign grant_d    = can_issue && d_req && (!if_req || (last_grant == GR_IF));
    assign grant_if   = can_issue && if_req && !grant_d;
    assign issue      = grant_d || grant_if;
    assign done       = !rst && busy_last;
    assign d_err_req  = !is_legal_mode(d_wen, d_mode) || d_misaligned;
    assign if_err_req = (if_addr[1:0] != 2'b00);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_grant <= GR_IF;
            cap_gr     <= GR_IF;
            cap_a      <= 2'd0;
            cap_mode   <= 3'd0;
            cap_wen    <= 1'b0;
            cap_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            if (issue) begin
                cap_gr   <= grant_d ? GR_D : GR_IF;
                cap_a    <= grant_d ? d_addr[1:0] : if_addr[1:0];
                cap_mode <= d_mode;
                cap_wen  <= grant_d && d_wen;
                cap_err  <= grant_d ? d_err_req : if_err_req;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 2'd0;
                end
            end
            BUSY: begin
                if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + 2'd1;
                end else if (issue) begin
                    cnt_nxt = 2'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (issue) begin
            last_grant_nxt = grant_d ? GR_D : GR_IF;
        end
    end

    always_comb begin
        if_ready  = grant_if;
        d_ready   = grant_d;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = 30'd0;
        ram_wdata = 32'd0;
        // Errored requests are acknowledged but never reach the RAM.
        if (grant_d && !d_err_req) begin
            ram_en    = 1'b1;
            ram_we    = d_wen;
            ram_be    = d_wen ? st_be : 4'b1111;
            ram_addr  = d_addr[31:2];
            ram_wdata = d_wen ? st_wdata : 32'd0;
        end else if (grant_if && !if_err_req) begin
            ram_en    = 1'b1;
            ram_be    = 4'b1111;
            ram_addr  = if_addr[31:2];
        end

        if_rvalid = done && (cap_gr == GR_IF);
        if_err    = if_rvalid && cap_err;
        if_rdata  = (if_rvalid && !cap_err) ? ram_rdata : 32'd0;
        d_rvalid  = done && (cap_gr == GR_D);
        d_err     = d_rvalid && cap_err;
        d_rdata   = (d_rvalid && !cap_err && !cap_wen) ? ld_data : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM_LAT=1 instance driven from a vector table
// with a response scoreboard, plus a RAM_LAT=3 instance for reset/latency cases.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- DUT A: RAM_LAT = 1 ----------------
    logic        rst, if_req, d_req, d_wen;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_mode;
    logic        if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    arb_state_t  dbg_state;

    mem_port_arbiter #(.RAM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_wen(d_wen), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    assign ram_rdata = rd_q;

    always @(posedge clk) begin
        if (rst) begin
            mem[4]  <= 32'h0050_0093;
            mem[64] <= 32'h80FF_1234;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_be[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
            end else begin
                rd_q <= mem[ram_addr[7:0]];
            end
        end
    end

    // ---------------- DUT B: RAM_LAT = 3 ----------------
    logic        b_rst, b_if_req, b_d_req, b_d_wen;
    logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
    logic [2:0]  b_d_mode;
    logic        b_if_ready, b_if_rvalid, b_if_err, b_d_ready, b_d_rvalid, b_d_err;
    logic [31:0] b_if_rdata, b_d_rdata, b_ram_wdata, b_ram_rdata;
    logic        b_ram_en, b_ram_we;
    logic [3:0]  b_ram_be;
    logic [29:0] b_ram_addr;
    arb_state_t  b_dbg_state;

    mem_port_arbiter #(.RAM_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .if_err(b_if_err),
        .d_req(b_d_req), .d_wen(b_d_wen), .d_mode(b_d_mode), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_be(b_ram_be), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .dbg_state(b_dbg_state)
    );

    logic [31:0] mem2 [0:255];
    logic [31:0] p0, p1, p2;
    assign b_ram_rdata = p2;

    always @(posedge clk) begin
        if (b_rst) begin
            mem2[8] <= 32'h1234_5678;
            mem2[9] <= 32'hA5A5_0001;
        end else if (b_ram_en && b_ram_we) begin
            for (int i = 0; i < 4; i++)
                if (b_ram_be[i]) mem2[b_ram_addr[7:0]][8*i +: 8] <= b_ram_wdata[8*i +: 8];
        end
        if (b_ram_en && !b_ram_we) p0 <= mem2[b_ram_addr[7:0]];
        p1 <= p0;
        p2 <= p1;
    end

    // ---------------- scoreboard for DUT A ----------------
    // Entry: {is_if, err, rdata}; issue cycle kept alongside for the latency check.
    logic [33:0] exp_q[$];
    int          iss_q[$];

    always begin
        logic [33:0] e;
        int          ic;
        @(negedge clk);
        #2;
        if (!rst && (if_rvalid || d_rvalid)) begin
            check1("one_rvalid_per_cycle", if_rvalid && d_rvalid, 1'b0);
            check1("rvalid_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ic = iss_q.pop_front();
                check1("rvalid_owner_if", if_rvalid, e[33]);
                check32("rvalid_latency", 32'(cyc - ic), 32'd1);
                if (e[33]) begin
                    check32("if_rdata", if_rdata, e[31:0]);
                    check1("if_err", if_err, e[32]);
                end else begin
                    check32("d_rdata", d_rdata, e[31:0]);
                    check1("d_err", d_err, e[32]);
                end
            end
        end
    end

    typedef struct {
        logic        is_if;
        logic        wen;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic is_if, input logic wen, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_en, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.is_if = is_if; v.wen = wen; v.mode = mode; v.addr = addr; v.wdata = wdata;
        v.exp_en = exp_en; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic got;
        got = 1'b0;
        @(negedge clk);
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_wen = v.wen; d_mode = v.mode; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (v.is_if ? if_ready : d_ready) begin
                got = 1'b1;
                check1($sformatf("v%0d_ram_en", idx), ram_en, v.exp_en);
                check1($sformatf("v%0d_ram_we", idx), ram_we, v.exp_en & v.wen);
                if (v.exp_en) begin
                    check32($sformatf("v%0d_ram_be", idx), 32'(ram_be), 32'(v.exp_be));
                    check32($sformatf("v%0d_ram_addr", idx), 32'(ram_addr), 32'(v.addr[31:2]));
                    if (v.wen) check32($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.exp_wdata);
                end
                exp_q.push_back({v.is_if, v.exp_err, v.exp_rdata});
                iss_q.push_back(cyc);
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check1($sformatf("v%0d_ready_seen", idx), got, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        check1($sformatf("v%0d_response_seen", idx), exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[17];
        logic [3:0]  ord;
        int          seen;
        int          rdy_cyc[$];
        int          rv_cyc[$];
        logic [31:0] rv_dat[$];

        vt[0]  = mk(1, 0, LW,    32'h010, 0,            1, 4'b1111, 0,            32'h0050_0093, 0);
        vt[1]  = mk(0, 0, LB,    32'h103, 0,            1, 4'b1111, 0,            32'hFFFF_FF80, 0);
        vt[2]  = mk(0, 0, LBU,   32'h103, 0,            1, 4'b1111, 0,            32'h0000_0080, 0);
        vt[3]  = mk(0, 0, LH,    32'h102, 0,            1, 4'b1111, 0,            32'hFFFF_80FF, 0);
        vt[4]  = mk(0, 0, LHU,   32'h100, 0,            1, 4'b1111, 0,            32'h0000_1234, 0);
        vt[5]  = mk(0, 1, SB,    32'h101, 32'h0000_00AB, 1, 4'b0010, 32'hABAB_ABAB, 32'h0,         0);
        vt[6]  = mk(0, 0, LW,    32'h100, 0,            1, 4'b1111, 0,            32'h80FF_AB34, 0);
        vt[7]  = mk(0, 1, SH,    32'h102, 32'h0000_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0);
        vt[8]  = mk(0, 0, LW,    32'h100, 0,            1, 4'b1111, 0,            32'hBEEF_AB34, 0);
        vt[9]  = mk(0, 0, LW,    32'h102, 0,            0, 4'b0000, 0,            32'h0,         1);
        vt[10] = mk(0, 0, 3'b011, 32'h100, 0,           0, 4'b0000, 0,            32'h0,         1);
        vt[11] = mk(1, 0, LW,    32'h012, 0,            0, 4'b0000, 0,            32'h0,         1);
        vt[12] = mk(0, 0, LHU,   32'h101, 0,            0, 4'b0000, 0,            32'h0,         1);
        vt[13] = mk(0, 1, SW,    32'h104, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D, 32'h0,         0);
        vt[14] = mk(0, 0, LW,    32'h104, 0,            1, 4'b1111, 0,            32'hCAFE_F00D, 0);
        vt[15] = mk(0, 1, 3'b100, 32'h100, 32'h55,      0, 4'b0000, 0,            32'h0,         1);
        vt[16] = mk(0, 0, LB,    32'h100, 0,            1, 4'b1111, 0,            32'h0000_0034, 0);

        // Both requesters held through reset so the first tie is decided by reset state.
        rst = 1'b1; b_rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_wen = 1'b0; d_mode = LW; d_addr = 32'h100; d_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0;
        b_d_req = 1'b0; b_d_wen = 1'b0; b_d_mode = LW; b_d_addr = 32'h0; b_d_wdata = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        check1("rst_if_ready", if_ready, 1'b0);
        check1("rst_d_ready", d_ready, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check1("rst_d_rvalid", d_rvalid, 1'b0);
        check1("rst_ram_en", ram_en, 1'b0);
        check1("rst_ram_we", ram_we, 1'b0);
        check32("rst_ram_be", 32'(ram_be), 32'd0);
        check32("rst_ram_addr", 32'(ram_addr), 32'd0);
        check32("rst_ram_wdata", ram_wdata, 32'd0);
        check32("rst_if_rdata", if_rdata, 32'd0);
        check32("rst_d_rdata", d_rdata, 32'd0);
        check1("rst_errs", if_err | d_err, 1'b0);
        check1("rst_state_busy", dbg_state == BUSY, 1'b0);

        // Tie: expected grant order D, I, D, I on consecutive cycles (bit set = data).
        @(negedge clk);
        rst = 1'b0;
        ord = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            #1;
            check1($sformatf("tie%0d_d_ready", g), d_ready, ord[g]);
            check1($sformatf("tie%0d_if_ready", g), if_ready, !ord[g]);
            if (d_ready) begin
                exp_q.push_back({1'b0, 1'b0, 32'h80FF_1234});
                iss_q.push_back(cyc);
            end
            if (if_ready) begin
                exp_q.push_back({1'b1, 1'b0, 32'h0050_0093});
                iss_q.push_back(cyc);
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        check1("tie_responses_seen", exp_q.size() == 0, 1'b1);

        for (int i = 0; i < 17; i++) run_vec(vt[i], i);

        // RAM_LAT=3: reset right after a load issue must suppress its response.
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        b_d_req = 1'b1; b_d_mode = LW; b_d_addr = 32'h20;
        #1;
        check1("lat3_load_ready", b_d_ready, 1'b1);
        check1("lat3_load_ram_en", b_ram_en, 1'b1);
        @(negedge clk);
        b_d_req = 1'b0;
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (b_d_rvalid || b_if_rvalid) seen++;
            @(negedge clk);
        end
        check32("lat3_no_rvalid_after_rst", 32'(seen), 32'd0);
        check1("lat3_idle_after_rst", b_dbg_state == IDLE, 1'b1);

        // Two fetches held back to back: the second is taken in the final BUSY cycle.
        b_if_req = 1'b1; b_if_addr = 32'h20;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (b_if_ready) rdy_cyc.push_back(cyc);
            if (b_if_rvalid) begin
                rv_cyc.push_back(cyc);
                rv_dat.push_back(b_if_rdata);
            end
            @(negedge clk);
            if (rdy_cyc.size() == 1) b_if_addr = 32'h24;
            else if (rdy_cyc.size() >= 2) b_if_req = 1'b0;
        end
        check32("lat3_ready_count", 32'(rdy_cyc.size()), 32'd2);
        check32("lat3_rvalid_count", 32'(rv_cyc.size()), 32'd2);
        if (rdy_cyc.size() == 2 && rv_cyc.size() == 2) begin
            check32("lat3_issue_spacing", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'd3);
            check32("lat3_first_latency", 32'(rv_cyc[0] - rdy_cyc[0]), 32'd3);
            check32("lat3_second_latency", 32'(rv_cyc[1] - rdy_cyc[1]), 32'd3);
            check32("lat3_first_rdata", rv_dat[0], 32'h1234_5678);
            check32("lat3_second_rdata", rv_dat[1], 32'hA5A5_0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
